// File: rtl/alu_pkg.sv
// Shared types for the ALU command initiator: op codes, command payload, data width.
package alu_pkg;
  localparam int DATA_W    = 8;
  // The tag field width is fixed here; the top-level TAG_W should match it.
  localparam int CMD_TAG_W = 2;

  typedef enum logic [1:0] {
    ADD    = 2'b00,
    SUB    = 2'b01,
    AND_OP = 2'b10,
    OR_OP  = 2'b11
  } alu_op_e;

  typedef struct packed {
    alu_op_e              op;
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;
    logic                 chain;
    logic [CMD_TAG_W-1:0] tag;
  } alu_cmd_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; push into a full FIFO and pop from an empty one are ignored.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  alu_cmd_t               din,
  output alu_cmd_t               head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  alu_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/alu_cmd_initiator.sv
// Buffers ALU commands, issues them one at a time to an external combinational ALU,
// and returns each registered result with its tag; chained commands reuse the last result.
module alu_cmd_initiator
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_chain,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [TAG_W-1:0]  rsp_tag
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e                 state;
  logic [DATA_W-1:0]      acc;
  alu_cmd_t               din, head;
  logic                   full, empty, push, pop;
  logic [$clog2(DEPTH):0] count;

  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == ISSUE);
  assign din       = '{op: alu_op_e'(cmd_op), a: cmd_a, b: cmd_b, chain: cmd_chain,
                       tag: CMD_TAG_W'(cmd_tag)};

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // ALU operands come only from the FIFO head and acc, never from the command port.
  assign alu_op = (state == ISSUE) ? head.op : 2'b00;
  assign alu_a  = (state == ISSUE) ? (head.chain ? acc : head.a) : '0;
  assign alu_b  = (state == ISSUE) ? head.b : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_tag    <= '0;
    end else begin
      case (state)
        IDLE: if (!empty) state <= ISSUE;
        ISSUE: begin
          acc        <= alu_result;
          rsp_result <= alu_result;
          rsp_tag    <= TAG_W'(head.tag);
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          // A command pushed this very cycle counts as pending.
          state     <= ((count != '0) || push) ? ISSUE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_initiator.sv
// Directed and random-stream checks of alu_cmd_initiator with a behavioural ALU attached.
module tb_alu_cmd_initiator;
  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_chain;
  logic [1:0] cmd_op, cmd_tag;
  logic [7:0] cmd_a, cmd_b;
  logic [1:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_result;
  logic [1:0] rsp_tag;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  alu_cmd_initiator #(.DEPTH(4), .TAG_W(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain), .cmd_tag(cmd_tag),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag)
  );

  function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic chain, input logic [1:0] tag);
    int n = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain; cmd_tag = tag;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("push_timeout", 32'(n), 0);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pop_rsp(input string tag, input logic [7:0] res, input logic [1:0] t);
    int n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    chk({tag, "_valid"}, 32'(rsp_valid), 1);
    chk({tag, "_result"}, 32'(rsp_result), 32'(res));
    chk({tag, "_tag"}, 32'(rsp_tag), 32'(t));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_dropped"}, 32'(rsp_valid), 0);
  endtask

  initial begin
    logic [9:0]  q[$];
    logic [9:0]  e;
    logic [7:0]  macc, prev_res;
    logic [1:0]  prev_tag;
    logic        hold, acc_now;
    int          sent, cyc;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_chain = 1'b0; cmd_tag = '0; rsp_ready = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_result", 32'(rsp_result), 0);
    chk("rst_rsp_tag", 32'(rsp_tag), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_alu", {8'h0, 6'h0, alu_op, alu_a, alu_b}, 0);
    rst = 1'b0;
    tick();

    // Single ADD with cycle-exact latency.
    cmd_op = 2'd0; cmd_a = 8'h12; cmd_b = 8'h34; cmd_chain = 1'b0; cmd_tag = 2'd1;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("lat_n1_valid", 32'(rsp_valid), 0);
    tick();
    chk("lat_issue_op", 32'(alu_op), 0);
    chk("lat_issue_a", 32'(alu_a), 32'h12);
    chk("lat_issue_b", 32'(alu_b), 32'h34);
    chk("lat_n2_valid", 32'(rsp_valid), 0);
    tick();
    chk("lat_n3_valid", 32'(rsp_valid), 1);
    chk("lat_result", 32'(rsp_result), 32'h46);
    chk("lat_tag", 32'(rsp_tag), 1);
    chk("resp_alu_idle", 32'(alu_a), 0);
    pop_rsp("add", 8'h46, 2'd1);

    // Modulo-256 wrap.
    push(2'd1, 8'h00, 8'h01, 1'b0, 2'd2);
    pop_rsp("sub_wrap", 8'hFF, 2'd2);
    push(2'd0, 8'hF0, 8'h20, 1'b0, 2'd3);
    pop_rsp("add_wrap", 8'h10, 2'd3);

    // Chain: 5+3=8, 8-2=6, 6|0x80=0x86.
    push(2'd0, 8'h05, 8'h03, 1'b0, 2'd0);
    push(2'd1, 8'hAA, 8'h02, 1'b1, 2'd1);
    push(2'd3, 8'hAA, 8'h80, 1'b1, 2'd2);
    pop_rsp("chain0", 8'h08, 2'd0);
    pop_rsp("chain1", 8'h06, 2'd1);
    pop_rsp("chain2", 8'h86, 2'd2);

    // Backpressure: one issued, four queued, sixth command refused.
    push(2'd0, 8'h01, 8'h02, 1'b0, 2'd0);
    push(2'd1, 8'h0A, 8'h03, 1'b0, 2'd1);
    push(2'd2, 8'hF0, 8'h3C, 1'b0, 2'd2);
    push(2'd3, 8'h0F, 8'h50, 1'b0, 2'd3);
    push(2'd0, 8'hFF, 8'h02, 1'b0, 2'd0);
    cmd_op = 2'd0; cmd_a = 8'h11; cmd_b = 8'h11; cmd_chain = 1'b0; cmd_tag = 2'd1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_cmd_ready", 32'(cmd_ready), 0);
      chk("bp_stable", {22'h0, rsp_valid, rsp_tag, rsp_result}, {22'h0, 1'b1, 2'd0, 8'h03});
      tick();
    end
    cmd_valid = 1'b0;
    pop_rsp("bp0", 8'h03, 2'd0);
    pop_rsp("bp1", 8'h07, 2'd1);
    pop_rsp("bp2", 8'h30, 2'd2);
    pop_rsp("bp3", 8'h5F, 2'd3);
    pop_rsp("bp4", 8'h01, 2'd0);
    repeat (4) tick();
    chk("bp_no_extra", 32'(rsp_valid), 0);

    // Reset while in RESP with two commands queued.
    push(2'd0, 8'h20, 8'h01, 1'b0, 2'd0);
    push(2'd0, 8'h30, 8'h01, 1'b0, 2'd1);
    push(2'd0, 8'h40, 8'h01, 1'b0, 2'd2);
    chk("mid_in_resp", {23'h0, rsp_valid, rsp_result}, {23'h0, 1'b1, 8'h21});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_cmd_ready", 32'(cmd_ready), 1);
    chk("mid_rsp_result", 32'(rsp_result), 0);
    push(2'd0, 8'h55, 8'h07, 1'b1, 2'd1);
    pop_rsp("post_rst", 8'h07, 2'd1);
    repeat (5) tick();
    chk("post_rst_discard", 32'(rsp_valid), 0);

    // Random stream against a reference model.
    rst = 1'b1; tick(); rst = 1'b0;
    macc = '0; hold = 1'b0; prev_res = '0; prev_tag = '0; sent = 0; cyc = 0;
    while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
      if (!cmd_valid && sent < 1000 && $urandom_range(3) != 0) begin
        cmd_op = 2'($urandom_range(3)); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
        cmd_chain = 1'($urandom_range(1)); cmd_tag = 2'($urandom_range(3));
        cmd_valid = 1'b1;
      end
      rsp_ready = 1'($urandom_range(1));
      if (hold)
        chk("rnd_stall_stable", {21'h0, rsp_valid, rsp_tag, rsp_result}, {21'h0, 1'b1, prev_tag, prev_res});
      acc_now = cmd_valid && cmd_ready;
      if (acc_now) begin
        macc = alu_f(cmd_op, cmd_chain ? macc : cmd_a, cmd_b);
        q.push_back({cmd_tag, macc});
        sent++;
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) chk("rnd_extra_rsp", 1, 0);
        else begin
          e = q.pop_front();
          chk("rnd_rsp", {22'h0, rsp_tag, rsp_result}, {22'h0, e});
        end
      end
      hold = rsp_valid && !rsp_ready;
      prev_res = rsp_result; prev_tag = rsp_tag;
      tick();
      cyc++;
      if (acc_now) cmd_valid = 1'b0;
    end
    rsp_ready = 1'b0;
    chk("rnd_complete", {sent, 32'(q.size())} == {32'd1000, 32'd0} ? 1 : 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/alu_cmd_initiator.md
# alu_cmd_initiator

Initiator-side companion to the team's dedicated-resource combinational ALU (2-bit op code; 8-bit operands and result). The block accepts operation commands over a valid/ready handshake and buffers them in a 4-entry FIFO. It issues each command to the ALU, registers the ALU result, and returns it with its tag over a valid/ready response channel. An optional chain bit substitutes the previous result for operand A, so multi-step accumulations run without host round-trips.

## Interface
- DEPTH, 4, command FIFO entries; power of two, at least 2
- TAG_W, 2, tag width carried from command to response
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_op  in  2  00 ADD, 01 SUB, 10 AND, 11 OR
- cmd_a  in  8  operand A; ignored when cmd_chain=1
- cmd_b  in  8  operand B
- cmd_chain  in  1  use the accumulator as operand A
- cmd_tag  in  TAG_W  returned unchanged with the result
- alu_op  out  2  op code to the ALU
- alu_a  out  8  operand A to the ALU
- alu_b  out  8  operand B to the ALU
- alu_result  in  8  combinational ALU result for the current alu_* outputs
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts the response
- rsp_result  out  8  registered result
- rsp_tag  out  TAG_W  tag of the command that produced rsp_result

## Operation
- Command accept: a command is pushed when cmd_valid && cmd_ready. cmd_ready = !full.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if the FIFO is not empty, go to ISSUE.
  - ISSUE: the FIFO head drives alu_op and alu_b. alu_a = head.chain ? acc : head.a. At the end of the cycle:
    - capture alu_result into rsp_result and acc;
    - capture the head tag into rsp_tag;
    - pop the FIFO;
    - go to RESP.
  - RESP: rsp_valid=1. On rsp_ready, go to ISSUE if the FIFO is non-empty after this cycle's push; otherwise go to IDLE. Without rsp_ready, stay in RESP with all response outputs stable.
- Outside ISSUE: alu_op, alu_a and alu_b drive 0.
- Arithmetic: all results are modulo 256. SUB is a−b in two's complement; 0x00−0x01 gives 0xFF. There are no carry or borrow flags.
- Accumulator: acc updates only on ISSUE capture. A chained command uses the result of the immediately preceding issued command, whatever its tag.
- Full FIFO: push is blocked by cmd_ready=0. When the FIFO is full, a pop in ISSUE frees a slot for the next cycle only; there is no same-cycle push-through.
- Simultaneous push and pop on a non-full FIFO: both take effect and the count is unchanged.
- Empty FIFO in IDLE: the FSM stays in IDLE.
- Reset, including mid-operation:
  - FIFO emptied, state IDLE, acc=0.
  - rsp_valid=0, rsp_result=0, rsp_tag=0, cmd_ready=1, alu_* = 0.
  - An in-flight command or response is discarded.

## Timing
- Latency: a command accepted at edge N into an empty FIFO with the FSM in IDLE:
  - IDLE at N+1 (FIFO now non-empty);
  - ISSUE at N+2 (alu_* driven, result captured);
  - rsp_valid=1 from N+3.
- Throughput: one command per 2 cycles (ISSUE, RESP) when rsp_ready is held high.
- ALU path: alu_result is sampled in the same cycle alu_* are driven. The external ALU must meet a single-cycle combinational path.
- Handshake rules: no combinational path from rsp_ready to cmd_ready, and none from cmd_valid to the alu_* outputs.

## Structure
- Shared package alu_pkg holds:
  - alu_op_e enum (ADD, SUB, AND_OP, OR_OP);
  - alu_cmd_t struct (op, a, b, chain, tag);
  - DATA_W=8.
- Sub-module alu_cmd_fifo: synchronous FIFO of alu_cmd_t with push, pop, full, empty and count.
- The FSM, accumulator and response register stay in alu_cmd_initiator.

## Test plan
- Single ADD: cmd (ADD, 0x12, 0x34, tag 1) into an idle block -> rsp_valid at cycle N+3 with result 0x46, tag 1.
- Wrap: SUB 0x00−0x01 -> 0xFF. ADD 0xF0+0x20 -> 0x10.
- Chain: ADD 5+3 (tag 0), then chained SUB b=2 (tag 1), then chained OR b=0x80 (tag 2) -> responses 0x08, 0x06, 0x86 in order.
- Backpressure and full:
  - hold rsp_ready=0 and push 6 commands;
  - expect 1 command issued, 4 in the FIFO, cmd_ready=0, and the response stable for 10 cycles;
  - release rsp_ready -> all 5 responses in order, with no loss or duplication.
- Reset mid-operation: assert rst while in RESP with 2 commands queued -> next cycle rsp_valid=0, cmd_ready=1, acc=0. A following chained ADD b=7 returns 0x07.
- Random stream against a reference model: 1000 commands with random rsp_ready -> results and tags match the model and rsp_* hold stable while stalled.
